dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported dataMemory.
- Shares dataMemory between the CPU load/store path (port 0) and a secondary master (port 1), for example a debug/DMA loader.
- Per-port handshake is req/gnt/done. Round-robin selection when both ports request.
- Range-checks addresses, registers the read data, and returns it with a one-cycle done pulse.

Parameters:
- MEM_DEPTH, 64: number of 32-bit words in dataMemory; valid word index is 0..MEM_DEPTH-2 (matches the memory's address < 63 guard).
- ADDR_W, 32: width of address buses.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request, held until gnt seen.
- we0 / we1  in  1  1 = write, 0 = read; valid while req is high.
- addr0 / addr1  in  ADDR_W  word index.
- wdata0 / wdata1  in  32  write data.
- gnt0 / gnt1  out  1  high for the single ACCESS cycle serving that port.
- done0 / done1  out  1  one-cycle pulse the cycle after ACCESS.
- rdata0 / rdata1  out  32  read result, valid while done is high, held until the port's next done.
- err0 / err1  out  1  valid with done: address out of range.
- memAddress  out  ADDR_W  to dataMemory address.
- memWriteData  out  32  to dataMemory writeData.
- memWrite  out  1  to dataMemory memWrite.
- memRead  out  1  to dataMemory memRead.
- memReadData  in  32  from dataMemory readData.

Behaviour:
- FSM states are IDLE and ACCESS.
- Reset values: state = IDLE; lastGrant = 1, so port 0 wins the first tie. All of gnt*, done*, err*, rdata*, memWrite, memRead, memAddress and memWriteData are 0.
- IDLE, no req: stay in IDLE. Memory outputs are 0; memRead = 0, memWrite = 0.
- IDLE, one req high: that port wins.
- IDLE, both req high: the port != lastGrant wins.
- On the winning edge: latch winner, we, addr and wdata into registers; set lastGrant = winner; go to ACCESS.
- ACCESS (exactly one cycle):
  - gnt[winner] = 1.
  - memAddress = latched addr; memWriteData = latched wdata.
  - memWrite = we & inRange & ~reset.
  - memRead = ~we & inRange.
  - inRange = (addr < MEM_DEPTH-1). Use a full-width unsigned compare; upper bits are never truncated.
  - dataMemory commits the write at the negedge inside this cycle.
  - req inputs are ignored during ACCESS.
  - At the ending edge, capture rdata[winner]:
    - memReadData if it was an in-range read;
    - 0 if it was out of range;
    - unchanged if it was an in-range write.
  - Same edge: set err[winner] = ~inRange, pulse done[winner] next cycle, return to IDLE.
- Latency: req high at cycle 0 → gnt in cycle 1 → done/rdata/err in cycle 2. The IDLE cycle 2 may accept a new request.
- Throughput: one access per 2 cycles. Alternation is guaranteed under continuous contention.
- Requester protocol: deassert req (or present the next request) at the edge ending the gnt cycle. A req still high in cycle 2 is a new request.
- The losing port keeps req high and is served in the next ACCESS; no starvation.
- Out-of-range write: no memory update; done with err = 1.
- Out-of-range read: rdata = 0, err = 1.
- Reset during ACCESS:
  - memWrite is forced low that cycle, so no write occurs.
  - The next state is IDLE with all outputs at reset values.
  - No done is issued; rdata is cleared.
- Reset asserted with req high: no grant until the first edge after reset drops.
- Only one of gnt0/gnt1 is ever high; only one done is ever high.

Decomposition:
- Shared include/package holds:
  - state encodings IDLE = 1'b0, ACCESS = 1'b1;
  - port index constants PORT_CPU = 0, PORT_AUX = 1;
  - the MEM_DEPTH default.
- One sub-module: rr_arb2. It is combinational winner selection from req0, req1 and lastGrant, outputting winner and anyReq.
- dmem_arbiter instantiates rr_arb2 and holds the FSM, latches and response registers.

Test Plan:
- Reset, then port 0 writes addr 5 = 0xDEADBEEF → gnt0 in cycle 1, memWrite = 1 with memAddress = 5, done0 in cycle 2 with err0 = 0.
- Port 1 reads addr 5 → gnt1, memRead = 1, done1 with rdata1 = 0xDEADBEEF, err1 = 0.
- req0 and req1 both held high for 8 cycles, both reading addr 5 → gnt sequence 0,1,0,1; done pulses alternate; never simultaneous.
- Port 0 writes addr 63 with 0x12345678, then reads addr 63 → memWrite stays 0; done0 with err0 = 1; read returns rdata0 = 0, err0 = 1.
- Port 0 writes addr 7 = 0xAAAA5555 with reset asserted during the ACCESS cycle → memWrite = 0; no done0; a subsequent read of addr 7 returns the prior value.
- Port 1 reads addr 0x1_0000_0002 (upper bits set) → err1 = 1, rdata1 = 0; no aliasing to word 2.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the dataMemory arbiter slice.
//   - FSM state encoding (Idle / Access)
//   - port index constants for the CPU load/store port and the auxiliary master
//   - default dataMemory depth in 32-bit words
package dmem_arbiter_pkg;

    typedef enum logic {
        StIdle   = 1'b0,
        StAccess = 1'b1
    } arbState_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int unsigned MEM_DEPTH_DEFAULT = 64;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin winner selection (purely combinational).
// Ports:
//   req0, req1  - pending requests from port 0 / port 1
//   lastGrant   - port served by the most recent access
//   winner      - port to serve next (only meaningful when anyReq is high)
//   anyReq      - at least one request is pending
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic lastGrant,
    output logic winner,
    output logic anyReq
);

    always_comb begin
        anyReq = req0 | req1;
        if (req0 && req1) begin
            // On a tie, the port that was not served last time goes first.
            winner = ~lastGrant;
        end else if (req1) begin
            winner = PORT_AUX;
        end else begin
            winner = PORT_CPU;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported dataMemory.
// Each access takes two cycles: Idle (select and latch a request) then Access
// (drive the memory for one cycle, capture the result). done/rdata/err appear in
// the cycle after Access.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   req*/we*/addr*/wdata*      - per-port request (held until gnt)
//   gnt*                       - high during the Access cycle serving that port
//   done*/rdata*/err*          - one-cycle completion pulse, read data, range error
//   memAddress/memWriteData/
//   memWrite/memRead           - dataMemory control, driven only during Access
//   memReadData                - dataMemory read data
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [31:0]       rdata0,
    output logic [31:0]       rdata1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] memAddress,
    output logic [31:0]       memWriteData,
    output logic              memWrite,
    output logic              memRead,
    input  logic [31:0]       memReadData
);

    // The memory rejects the top word, so valid indices are 0..MEM_DEPTH-2.
    // Compared at the full address width so upper bits can never alias.
    localparam logic [ADDR_W-1:0] WordLimit = ADDR_W'(MEM_DEPTH - 1);

    arbState_e         stateQ, stateD;
    logic              winnerQ, winnerD;
    logic              lastGrantQ, lastGrantD;
    logic              weQ, weD;
    logic [ADDR_W-1:0] addrQ, addrD;
    logic [31:0]       wdataQ, wdataD;
    logic              done0Q, done0D, done1Q, done1D;
    logic              err0Q, err0D, err1Q, err1D;
    logic [31:0]       rdata0Q, rdata0D, rdata1Q, rdata1D;

    logic winner;
    logic anyReq;
    logic inRange;

    rr_arb2 uArb (
        .req0      (req0),
        .req1      (req1),
        .lastGrant (lastGrantQ),
        .winner    (winner),
        .anyReq    (anyReq)
    );

    assign inRange = (addrQ < WordLimit);

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ     <= StIdle;
            winnerQ    <= PORT_CPU;
            lastGrantQ <= PORT_AUX;
            weQ        <= 1'b0;
            addrQ      <= '0;
            wdataQ     <= '0;
            done0Q     <= 1'b0;
            done1Q     <= 1'b0;
            err0Q      <= 1'b0;
            err1Q      <= 1'b0;
            rdata0Q    <= '0;
            rdata1Q    <= '0;
        end else begin
            stateQ     <= stateD;
            winnerQ    <= winnerD;
            lastGrantQ <= lastGrantD;
            weQ        <= weD;
            addrQ      <= addrD;
            wdataQ     <= wdataD;
            done0Q     <= done0D;
            done1Q     <= done1D;
            err0Q      <= err0D;
            err1Q      <= err1D;
            rdata0Q    <= rdata0D;
            rdata1Q    <= rdata1D;
        end
    end

    always_comb begin
        stateD       = stateQ;
        winnerD      = winnerQ;
        lastGrantD   = lastGrantQ;
        weD          = weQ;
        addrD        = addrQ;
        wdataD       = wdataQ;
        done0D       = 1'b0;
        done1D       = 1'b0;
        err0D        = err0Q;
        err1D        = err1Q;
        rdata0D      = rdata0Q;
        rdata1D      = rdata1Q;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        memAddress   = '0;
        memWriteData = '0;
        memWrite     = 1'b0;
        memRead      = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (anyReq) begin
                    stateD     = StAccess;
                    winnerD    = winner;
                    lastGrantD = winner;
                    if (winner == PORT_AUX) begin
                        weD    = we1;
                        addrD  = addr1;
                        wdataD = wdata1;
                    end else begin
                        weD    = we0;
                        addrD  = addr0;
                        wdataD = wdata0;
                    end
                end
            end

            StAccess: begin
                stateD       = StIdle;
                memAddress   = addrQ;
                memWriteData = wdataQ;
                // Reset gates the write strobe directly: the memory commits on the
                // negedge inside this cycle, before the reset edge takes effect.
                memWrite     = weQ & inRange & ~reset;
                memRead      = ~weQ & inRange;
                if (winnerQ == PORT_AUX) begin
                    gnt1   = 1'b1;
                    done1D = 1'b1;
                    err1D  = ~inRange;
                    if (!inRange) begin
                        rdata1D = '0;
                    end else if (!weQ) begin
                        rdata1D = memReadData;
                    end
                end else begin
                    gnt0   = 1'b1;
                    done0D = 1'b1;
                    err0D  = ~inRange;
                    if (!inRange) begin
                        rdata0D = '0;
                    end else if (!weQ) begin
                        rdata0D = memReadData;
                    end
                end
            end

            default: stateD = StIdle;
        endcase
    end

    assign done0  = done0Q;
    assign done1  = done1Q;
    assign err0   = err0Q;
    assign err1   = err1Q;
    assign rdata0 = rdata0Q;
    assign rdata1 = rdata1Q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int unsigned AW = 36;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [31:0]   wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1, err0, err1;
    logic [31:0]   rdata0, rdata1;
    logic [AW-1:0] memAddress;
    logic [31:0]   memWriteData, memReadData;
    logic          memWrite, memRead;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .MEM_DEPTH (64),
        .ADDR_W    (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .done0        (done0),
        .done1        (done1),
        .rdata0       (rdata0),
        .rdata1       (rdata1),
        .err0         (err0),
        .err1         (err1),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memWrite     (memWrite),
        .memRead      (memRead),
        .memReadData  (memReadData)
    );

    // dataMemory stand-in: writes on negedge, combinational read, address < 63 guard.
    logic [31:0] dmem [64];
    always @(negedge clk) begin
        if (memWrite && memAddress < 63) dmem[memAddress[5:0]] <= memWriteData;
    end
    assign memReadData = (memRead && memAddress < 63) ? dmem[memAddress[5:0]] : 32'h0;

    // Requester state, one entry per port.
    logic          pendActive [2];
    logic          pendWe     [2];
    logic [AW-1:0] pendAddr   [2];
    logic [31:0]   pendData   [2];
    bit            holdReq    [2];
    bit            randMode;

    assign req0   = pendActive[0];
    assign req1   = pendActive[1];
    assign we0    = pendWe[0];
    assign we1    = pendWe[1];
    assign addr0  = pendAddr[0];
    assign addr1  = pendAddr[1];
    assign wdata0 = pendData[0];
    assign wdata1 = pendData[1];

    // Reference model: which transaction is in service, and what each port should see.
    logic [31:0]   refMem [64];
    bit            mAccess, mDone;
    int            mPort, mDonePort;
    bit            mWe;
    logic [AW-1:0] mAddr;
    logic [31:0]   mData;
    int            mLast;
    logic [31:0]   expRdata [2];
    bit            expErr   [2];

    int nTests = 0;
    int nFail  = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model across one clock edge, using the inputs the DUT sampled.
    task automatic modelEdge();
        bit inR;
        int w;
        if (reset) begin
            mAccess = 0;
            mDone   = 0;
            mLast   = 1;
            expRdata[0] = 0; expRdata[1] = 0;
            expErr[0]   = 0; expErr[1]   = 0;
        end else if (mAccess) begin
            inR = (mAddr < 63);
            if (mWe && inR) refMem[mAddr[5:0]] = mData;
            if (!inR) expRdata[mPort] = 0;
            else if (!mWe) expRdata[mPort] = refMem[mAddr[5:0]];
            expErr[mPort] = !inR;
            mDone     = 1;
            mDonePort = mPort;
            mAccess   = 0;
        end else begin
            mDone = 0;
            if (pendActive[0] || pendActive[1]) begin
                if (pendActive[0] && pendActive[1]) w = (mLast == 0) ? 1 : 0;
                else w = pendActive[1] ? 1 : 0;
                mPort   = w;
                mWe     = pendWe[w];
                mAddr   = pendAddr[w];
                mData   = pendData[w];
                mLast   = w;
                mAccess = 1;
            end
        end
    endtask

    task automatic checkOutputs();
        bit inR;
        inR = mAccess && (mAddr < 63);
        checkVal("gnt0", gnt0, mAccess && mPort == 0);
        checkVal("gnt1", gnt1, mAccess && mPort == 1);
        checkVal("done0", done0, mDone && mDonePort == 0);
        checkVal("done1", done1, mDone && mDonePort == 1);
        checkVal("memWrite", memWrite, inR && mWe && !reset);
        checkVal("memRead", memRead, inR && !mWe);
        checkVal("memAddress", memAddress, mAccess ? mAddr : '0);
        checkVal("memWriteData", memWriteData, mAccess ? mData : 32'h0);
        checkVal("rdata0", rdata0, expRdata[0]);
        checkVal("rdata1", rdata1, expRdata[1]);
        if (mDone) checkVal("err", mDonePort ? err1 : err0, expErr[mDonePort]);
        checkVal("oneGnt", gnt0 & gnt1, 0);
        checkVal("oneDone", done0 & done1, 0);
    endtask

    function automatic logic [AW-1:0] randAddr();
        logic [AW-1:0] a;
        if ($urandom_range(0, 9) == 0) begin
            a = AW'($urandom_range(0, 63));
            a[AW-1:32] = 4'($urandom_range(1, 15));
        end else begin
            a = AW'($urandom_range(0, 63));
        end
        return a;
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutputs();
        // Requester drops its request at the edge ending its gnt cycle.
        if (mAccess && !holdReq[mPort]) pendActive[mPort] = 0;
        if (randMode) begin
            for (int p = 0; p < 2; p++) begin
                if (!pendActive[p] && $urandom_range(0, 2) != 0) begin
                    pendActive[p] = 1;
                    pendWe[p]     = $urandom_range(0, 1) == 1;
                    pendAddr[p]   = randAddr();
                    pendData[p]   = $urandom;
                end
            end
            reset = ($urandom_range(0, 49) == 0);
        end
    endtask

    task automatic issue(input int p, input bit we, input logic [AW-1:0] a, input logic [31:0] d);
        bit seen;
        pendActive[p] = 1;
        pendWe[p]     = we;
        pendAddr[p]   = a;
        pendData[p]   = d;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            stepCycle();
            seen = mDone && mDonePort == p;
        end
        if (!seen) checkVal("issue_timeout", 0, 1);
    endtask

    int g0, g1;

    initial begin
        for (int i = 0; i < 64; i++) begin
            dmem[i]   = 32'h0;
            refMem[i] = 32'h0;
        end
        for (int p = 0; p < 2; p++) begin
            pendActive[p] = 0; pendWe[p] = 0; pendAddr[p] = '0; pendData[p] = 0;
            holdReq[p] = 0;
        end
        randMode = 0;
        mAccess = 0; mDone = 0; mPort = 0; mDonePort = 0; mLast = 1;
        mWe = 0; mAddr = '0; mData = 0;
        expRdata[0] = 0; expRdata[1] = 0; expErr[0] = 0; expErr[1] = 0;

        // Reset held with a request pending: nothing may be granted.
        reset = 1;
        pendActive[1] = 1;
        pendAddr[1]   = AW'(3);
        stepCycle();
        stepCycle();
        checkVal("reset_err0", err0, 0);
        checkVal("reset_err1", err1, 0);
        pendActive[1] = 0;
        reset = 0;
        stepCycle();

        // Port 0 writes 5, port 1 reads it back.
        issue(0, 1, AW'(5), 32'hDEADBEEF);
        checkVal("plan_wr5_err0", err0, 0);
        issue(1, 0, AW'(5), 32'h0);
        checkVal("plan_rd5_rdata1", rdata1, 32'hDEADBEEF);
        checkVal("plan_rd5_err1", err1, 0);

        // Continuous contention: grants must alternate.
        pendActive[0] = 1; pendWe[0] = 0; pendAddr[0] = AW'(5);
        pendActive[1] = 1; pendWe[1] = 0; pendAddr[1] = AW'(5);
        holdReq[0] = 1; holdReq[1] = 1;
        g0 = 0; g1 = 0;
        for (int i = 0; i < 8; i++) begin
            stepCycle();
            g0 += int'(gnt0);
            g1 += int'(gnt1);
        end
        checkVal("contend_g0", g0, 2);
        checkVal("contend_g1", g1, 2);
        holdReq[0] = 0; holdReq[1] = 0;
        pendActive[0] = 0; pendActive[1] = 0;
        stepCycle();
        stepCycle();

        // Top word is out of range for both write and read.
        issue(0, 1, AW'(63), 32'h12345678);
        checkVal("plan_wr63_err0", err0, 1);
        issue(0, 0, AW'(63), 32'h0);
        checkVal("plan_rd63_rdata0", rdata0, 32'h0);
        checkVal("plan_rd63_err0", err0, 1);
        issue(0, 1, AW'(62), 32'h62626262);
        checkVal("plan_wr62_err0", err0, 0);

        // Reset during the Access cycle of a write must suppress it.
        issue(0, 1, AW'(7), 32'h11112222);
        pendActive[0] = 1; pendWe[0] = 1; pendAddr[0] = AW'(7); pendData[0] = 32'hAAAA5555;
        stepCycle();
        checkVal("rstacc_gnt0", gnt0, 1);
        reset = 1;
        #1;
        checkVal("rstacc_memWrite", memWrite, 0);
        stepCycle();
        checkVal("rstacc_done0", done0, 0);
        reset = 0;
        stepCycle();
        issue(0, 0, AW'(7), 32'h0);
        checkVal("rstacc_rd7", rdata0, 32'h11112222);

        // Upper address bits set must not alias onto word 2.
        issue(0, 1, AW'(2), 32'h22222222);
        issue(1, 0, 36'h1_0000_0002, 32'h0);
        checkVal("alias_err1", err1, 1);
        checkVal("alias_rdata1", rdata1, 32'h0);

        // Random traffic with occasional resets.
        randMode = 1;
        for (int i = 0; i < 400; i++) stepCycle();
        randMode = 0;
        reset = 0;

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
